// File: rtl/seq_mult_signmag.sv
// Sequential shift-and-add multiplier for sign/magnitude operand pairs.
// It multiplies the magnitudes over DW cycles. It then applies the product
// sign, giving a 2*DW+1 bit two's-complement result.
module seq_mult_signmag #(
    parameter int DW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [DW-1:0]   i_mcand,
    input  logic            i_mcand_sign,
    input  logic [DW-1:0]   i_mplier,
    input  logic            i_mplier_sign,
    output logic [2*DW:0]   o_product,
    output logic            o_sign,
    output logic            o_busy,
    output logic            o_done
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [DW-1:0]       mcand_q;
    logic [DW-1:0]       mplier_q;
    logic                sign_q;
    logic [2*DW-1:0]     acc_q;
    logic [CW-1:0]       cnt_q;
    logic [2*DW:0]       product_q;
    logic                osign_q;
    logic                busy_q;
    logic                done_q;

    logic [2*DW-1:0]     partial_d;
    logic [2*DW-1:0]     acc_d;

    // Convert a magnitude to two's complement. A zero magnitude never becomes a negative zero.
    function automatic logic [2*DW:0] apply_sign(input logic neg, input logic [2*DW-1:0] mag);
        logic [2*DW:0] ext;
        ext = {1'b0, mag};
        if (neg && (mag != '0)) begin
            return (~ext) + {{(2*DW){1'b0}}, 1'b1};
        end
        return ext;
    endfunction

    // Compute the shifted partial product and the next accumulator value for one MULT step.
    always_comb begin
        partial_d = {{DW{1'b0}}, mcand_q} << cnt_q;
        acc_d     = acc_q + (mplier_q[0] ? partial_d : '0);
    end

    // Run the control FSM, the datapath registers and the registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sign_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            osign_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        mcand_q  <= i_mcand;
                        mplier_q <= i_mplier;
                        sign_q   <= i_mcand_sign ^ i_mplier_sign;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= MULT;
                    end
                end
                MULT: begin
                    // Always DW iterations; the bench relies on fixed latency.
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    product_q <= apply_sign(sign_q, acc_q);
                    osign_q   <= sign_q && (acc_q != '0);
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_product = product_q;
    assign o_sign    = osign_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_seq_mult_signmag.sv
// Self-checking bench for seq_mult_signmag. It uses directed and randomized
// operands, which are compared against an arithmetic sign/magnitude model.
module tb_seq_mult_signmag;

    localparam int DW = 8;
    localparam int PW = 2 * DW + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [DW-1:0]   mcand;
    logic            mcand_sign;
    logic [DW-1:0]   mplier;
    logic            mplier_sign;
    logic [PW-1:0]   product;
    logic            sign;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    seq_mult_signmag #(.DW(DW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_mcand       (mcand),
        .i_mcand_sign  (mcand_sign),
        .i_mplier      (mplier),
        .i_mplier_sign (mplier_sign),
        .o_product     (product),
        .o_sign        (sign),
        .o_busy        (busy),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference result is the signed integer product, truncated to PW bits.
    function automatic logic [PW-1:0] ref_prod(input int mc, input bit ms, input int mp, input bit mps);
        int p;
        int v;
        logic [31:0] w;
        p = mc * mp;
        v = (ms ^ mps) ? -p : p;
        w = v;
        return w[PW-1:0];
    endfunction

    function automatic bit ref_sign(input int mc, input bit ms, input int mp, input bit mps);
        return (ms ^ mps) && (mc * mp != 0);
    endfunction

    // This task issues one request and waits for o_done, within a bound. After the
    // accepting edge it scrambles the operand inputs each cycle. It returns the edge count
    // to o_done, where the accepting edge counts as 1. It also returns the busy-cycle
    // count, the result, and the product sampled mid-operation.
    task automatic do_mult(input int mc, input bit ms, input int mp, input bit mps,
                           output int lat, output int busy_cnt,
                           output logic [PW-1:0] prod, output logic sgn,
                           output logic [PW-1:0] mid_prod);
        @(negedge clk);
        mcand = DW'(mc); mcand_sign = ms; mplier = DW'(mp); mplier_sign = mps;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        mid_prod = product;
        while (!done && lat < 40) begin
            mcand = DW'($urandom); mplier = DW'($urandom);
            mcand_sign = 1'($urandom); mplier_sign = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (lat == 5) mid_prod = product;
        end
        prod = product;
        sgn  = sign;
    endtask

    task automatic test_reset();
        start = 1'b0; mcand = '0; mplier = '0; mcand_sign = 1'b0; mplier_sign = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (product !== '0 || sign !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: product=%h sign=%b busy=%b done=%b required all 0",
                     product, sign, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int mcs [4] = '{3, 7, 255, 0};
        bit mss [4] = '{0, 1, 1, 0};
        int mps [4] = '{5, 6, 255, 100};
        bit mpss[4] = '{0, 0, 1, 1};
        int lat, bc;
        logic [PW-1:0] p, midp, exp_p;
        logic s, exp_s;
        for (int i = 0; i < 4; i++) begin
            do_mult(mcs[i], mss[i], mps[i], mpss[i], lat, bc, p, s, midp);
            exp_p = ref_prod(mcs[i], mss[i], mps[i], mpss[i]);
            exp_s = ref_sign(mcs[i], mss[i], mps[i], mpss[i]);
            checks++;
            if (lat !== DW + 2) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, DW + 2);
            end
            checks++;
            if (p !== exp_p || s !== exp_s) begin
                failures++;
                $display("FAIL directed_product[%0d]: got %h/%b required %h/%b", i, p, s, exp_p, exp_s);
            end
            checks++;
            if (bc !== DW + 2) begin
                failures++;
                $display("FAIL directed_busy_cycles[%0d]: got %0d required %0d", i, bc, DW + 2);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL directed_return_idle[%0d]: done=%b busy=%b required 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, mc, mp;
        bit ms, mps;
        logic [PW-1:0] p, midp, prev_p;
        logic s;
        prev_p = product;
        for (int i = 0; i < 24; i++) begin
            mc = (i % 6 == 0) ? 0 : int'($urandom_range(0, 255));
            mp = (i % 7 == 3) ? 0 : int'($urandom_range(0, 255));
            if (i % 5 == 1) mc = 255;
            ms = 1'($urandom); mps = 1'($urandom);
            do_mult(mc, ms, mp, mps, lat, bc, p, s, midp);
            checks++;
            if (midp !== prev_p) begin
                failures++;
                $display("FAIL random_hold[%0d]: mid-op product %h required previous %h", i, midp, prev_p);
            end
            checks++;
            if (lat !== DW + 2 || p !== ref_prod(mc, ms, mp, mps) || s !== ref_sign(mc, ms, mp, mps)) begin
                failures++;
                $display("FAIL random_op[%0d] %0d(%b)x%0d(%b): lat=%0d got %h/%b required %h/%b",
                         i, mc, ms, mp, mps, lat, p, s, ref_prod(mc, ms, mp, mps), ref_sign(mc, ms, mp, mps));
            end
            prev_p = p;
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int done_edges[$];
        @(negedge clk);
        for (int k = 0; k <= 32; k++) begin
            start = 1'b1;
            if (k % 11 == 0) begin
                mcand = 8'd2; mplier = 8'd2; mcand_sign = 1'b0; mplier_sign = 1'b0;
            end else begin
                mcand = DW'($urandom); mplier = DW'($urandom);
                mcand_sign = 1'($urandom); mplier_sign = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin
                done_edges.push_back(k);
                checks++;
                if (product !== 17'd4 || sign !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_product at edge %0d: got %h/%b required 00004/0", k, product, sign);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done_edges.size() != 3) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d required 3", done_edges.size());
        end else begin
            checks++;
            if (done_edges[0] != 9 || done_edges[1] - done_edges[0] != 11 || done_edges[2] - done_edges[1] != 11) begin
                failures++;
                $display("FAIL b2b_spacing: edges %0d %0d %0d required 9 20 31",
                         done_edges[0], done_edges[1], done_edges[2]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, saw_done;
        logic [PW-1:0] p, midp;
        logic s;
        @(negedge clk);
        mcand = 8'd9; mplier = 8'd9; mcand_sign = 1'b0; mplier_sign = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (product !== '0 || sign !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: product=%h sign=%b busy=%b done=%b required all 0",
                     product, sign, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) saw_done++;
        end
        checks++;
        if (saw_done != 0) begin
            failures++;
            $display("FAIL midreset_no_done: saw %0d busy/done cycles required 0", saw_done);
        end
        do_mult(9, 0, 9, 1, lat, bc, p, s, midp);
        checks++;
        if (lat !== DW + 2 || p !== 17'h1FFAF || s !== 1'b1) begin
            failures++;
            $display("FAIL midreset_restart: lat=%0d got %h/%b required 10 1ffaf/1", lat, p, s);
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
